// File: rtl/video_led_ovl_if.sv
// Pixel-stream, LED-hit and shadow-table write signals shared between the
// LED overlay and whatever drives it.
interface video_led_ovl_if #(
    parameter int C_LED_N = 18,
    parameter int C_HW    = 9,
    parameter int C_VW    = 8
);
    localparam int C_IW = $clog2(C_LED_N);

    logic                   CK_EE_i;
    logic [C_LED_N-1:0]     LEDs_ON_i;
    logic [C_HW-1:0]        HCTRs_i;
    logic [C_VW-1:0]        VCTRs_i;
    logic                   WR_i;
    logic [C_IW-1:0]        WR_IDXs_i;
    logic [C_HW+C_VW+5:0]   WR_DATs_i;
    logic                   WR_ACK_o;
    logic                   LED_HIT_o;
    logic [C_IW:0]          LED_IDXs_o;
    logic                   LED_COLOR_ON_o;
    logic [2:0]             LED_COLOR_PHs_o;

    modport master (
        output CK_EE_i, LEDs_ON_i, HCTRs_i, VCTRs_i, WR_i, WR_IDXs_i, WR_DATs_i,
        input  WR_ACK_o, LED_HIT_o, LED_IDXs_o, LED_COLOR_ON_o, LED_COLOR_PHs_o
    );

    modport slave (
        input  CK_EE_i, LEDs_ON_i, HCTRs_i, VCTRs_i, WR_i, WR_IDXs_i, WR_DATs_i,
        output WR_ACK_o, LED_HIT_o, LED_IDXs_o, LED_COLOR_ON_o, LED_COLOR_PHs_o
    );
endinterface

// File: rtl/video_led_ovl.sv
// LED sprite overlay: judges each pixel against a frame-latched sprite table and
// reports the lowest-index hit two pixel-enables later, with per-LED blinking.
module video_led_ovl #(
    parameter int C_LED_N = 18,
    parameter int C_HW    = 9,
    parameter int C_VW    = 8,
    parameter int C_HALF  = 7,
    parameter int C_SHAPE = 0,
    parameter logic [C_LED_N*24-1:0] C_LOCsss = {
        24'h0101A8, 24'h010190, 24'h010178, 24'h010160, 24'h010148, 24'h010130,
        24'h010118, 24'h010100, 24'h0100E8, 24'h0100D0, 24'h0100B8, 24'h0100A0,
        24'h010088, 24'h010070, 24'h010058, 24'h010040, 24'h010028, 24'h010010},
    parameter logic [C_LED_N*6-1:0] C_ATTRsss = {(C_LED_N*6){1'b0}}
) (
    input  logic           CK_i,
    input  logic           XARST_i,
    video_led_ovl_if.slave bus
);
    localparam int C_IW    = $clog2(C_LED_N);
    localparam int DW      = C_HW + C_VW + 6;
    localparam int DTW     = C_HW + 1;
    localparam int Y_LSB   = C_HW;
    localparam int ATTR_LSB = C_HW + C_VW;
    localparam logic [C_IW:0] NONE  = {(C_IW+1){1'b1}};
    localparam logic [DTW:0]  HALF_S = (DTW+1)'(C_HALF);

    function automatic logic [DTW-1:0] abs_diff(input logic [DTW-1:0] a, input logic [DTW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic blink_gate(input logic [1:0] mode, input logic slow, input logic fast);
        logic g;
        case (mode)
            2'd0:    g = 1'b1;
            2'd1:    g = ~slow;
            2'd2:    g = ~fast;
            2'd3:    g = slow;
            default: g = 1'b1;
        endcase
        return g;
    endfunction

    // Table entries are stored in write-bus order {BLINK, PH, COLOR_ON, Y, X}.
    function automatic logic [DW-1:0] reset_entry(input int idx);
        return {C_ATTRsss[idx*6 +: 2], C_ATTRsss[idx*6+2 +: 3], C_ATTRsss[idx*6+5],
                C_LOCsss[idx*24+12 +: C_VW], C_LOCsss[idx*24 +: C_HW]};
    endfunction

    logic [DW-1:0]      shadow_r [C_LED_N];
    logic [DW-1:0]      active_r [C_LED_N];
    logic [7:0]         frm_r;
    logic               tick_s;
    logic [C_LED_N-1:0] geo_hit_s;
    logic [C_IW:0]      win_s;
    logic               win_on_s;
    logic [5:0]         win_attr_s;
    logic [C_IW:0]      idx1_r, idx_r;
    logic               lit1_r, con1_r, hit_r, con_r, ack_r;
    logic [2:0]         ph1_r, ph_r;

    assign tick_s = bus.CK_EE_i && (bus.HCTRs_i == {C_HW{1'b0}}) && (bus.VCTRs_i == {C_VW{1'b0}});

    for (genvar g = 0; g < C_LED_N; g++) begin : g_geo
        logic [DTW-1:0] dx_s, dy_s;
        logic [DTW:0]   sum_s;
        assign dx_s  = abs_diff(DTW'(bus.HCTRs_i), DTW'(active_r[g][0 +: C_HW]));
        assign dy_s  = abs_diff(DTW'(bus.VCTRs_i), DTW'(active_r[g][Y_LSB +: C_VW]));
        assign sum_s = {1'b0, dx_s} + {1'b0, dy_s};
        assign geo_hit_s[g] = (C_SHAPE == 32'sd0)
                            ? (({1'b0, dx_s} <= HALF_S) && ({1'b0, dy_s} <= HALF_S))
                            : (sum_s <= HALF_S);
    end

    // Lowest geometric hit wins, whatever its on/blink state.
    always_comb begin
        win_s      = NONE;
        win_on_s   = 1'b0;
        win_attr_s = 6'd0;
        for (int i = C_LED_N - 1; i >= 0; i--) begin
            win_s      = geo_hit_s[i] ? (C_IW+1)'(i)              : win_s;
            win_on_s   = geo_hit_s[i] ? bus.LEDs_ON_i[i]          : win_on_s;
            win_attr_s = geo_hit_s[i] ? active_r[i][ATTR_LSB +: 6] : win_attr_s;
        end
    end

    // Shadow takes writes at any time; active snapshots shadow on frame ticks.
    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            for (int i = 0; i < C_LED_N; i++) begin
                shadow_r[i] <= reset_entry(i);
                active_r[i] <= reset_entry(i);
            end
        end else begin
            for (int i = 0; i < C_LED_N; i++) begin
                if (tick_s) active_r[i] <= shadow_r[i];
                if (bus.WR_i && (bus.WR_IDXs_i == C_IW'(i))) shadow_r[i] <= bus.WR_DATs_i;
            end
        end
    end

    // Frame counter and write acknowledge.
    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            frm_r <= 8'd0;
            ack_r <= 1'b0;
        end else begin
            ack_r <= bus.WR_i;
            if (tick_s) frm_r <= frm_r + 8'd1;
        end
    end

    // Two-stage judge pipeline, advancing only on pixel enable.
    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            idx1_r <= NONE;
            lit1_r <= 1'b0;
            con1_r <= 1'b0;
            ph1_r  <= 3'd0;
            idx_r  <= NONE;
            hit_r  <= 1'b0;
            con_r  <= 1'b0;
            ph_r   <= 3'd0;
        end else if (bus.CK_EE_i) begin
            idx1_r <= win_s;
            lit1_r <= win_on_s & blink_gate(win_attr_s[5:4], frm_r[5], frm_r[3]);
            con1_r <= win_attr_s[0];
            ph1_r  <= win_attr_s[3:1];
            idx_r  <= idx1_r;
            hit_r  <= lit1_r && (idx1_r != NONE);
            con_r  <= (idx1_r != NONE) ? con1_r : 1'b0;
            ph_r   <= (idx1_r != NONE) ? ph1_r : 3'd0;
        end
    end

    assign bus.WR_ACK_o        = ack_r;
    assign bus.LED_HIT_o       = hit_r;
    assign bus.LED_IDXs_o      = idx_r;
    assign bus.LED_COLOR_ON_o  = con_r;
    assign bus.LED_COLOR_PHs_o = ph_r;
endmodule
